// File: rtl/lpc_frame_mm_master.sv
// rtl/lpc_frame_mm_master.sv - Avalon-MM frame buffer master feeding the LPC analysis stage
//
// Purpose: writes one frame of FRAME_LEN signed samples into DDR with word
// writes, reads the frame back in order and streams it downstream.
// Optional feature macro: LPC_FRAME_PINGPONG_EN (alternate two frame regions).
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_data/in_valid/in_ready           sample input handshake
//   out_data/out_valid/out_last         read-back sample stream (no backpressure)
//   frame_done                          one-cycle pulse after a frame is streamed
//   ddr_addr/ddr_read/ddr_write         Avalon-MM command (word address)
//   ddr_writedata                       Avalon-MM write data
//   ddr_readdata/ddr_readdatavalid      Avalon-MM pipelined read response
//   ddr_waitrequest                     slave stall, holds the current command
module lpc_frame_mm_master #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int FRAME_LEN = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              frame_done,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_read,
  output logic              ddr_write,
  output logic [DATA_W-1:0] ddr_writedata,
  input  logic [DATA_W-1:0] ddr_readdata,
  input  logic              ddr_readdatavalid,
  input  logic              ddr_waitrequest
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] S_WRITE = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     wr_issued_q, wr_issued_d;
  logic [CW-1:0]     rd_issued_q, rd_issued_d;
  logic [CW-1:0]     rd_rcvd_q, rd_rcvd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] frame_base;
  logic              accept, wr_ack, rd_ack;

`ifdef LPC_FRAME_PINGPONG_EN
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BASE_ADDR + FRAME_LEN);
  logic bank_q, bank_d;
  assign frame_base = bank_q ? BASE1 : BASE0;
`else
  assign frame_base = BASE0;
`endif

  // A stalled write blocks new samples so the held command/data stay intact.
  assign in_ready = !reset && (state_q == S_WRITE) && (wr_issued_q < LEN)
                    && !(write_q && ddr_waitrequest);
  assign accept   = in_valid && in_ready;
  assign wr_ack   = write_q && !ddr_waitrequest;
  assign rd_ack   = read_q && !ddr_waitrequest;

  always_comb begin
    state_d      = state_q;
    wr_issued_d  = wr_issued_q;
    rd_issued_d  = rd_issued_q;
    rd_rcvd_d    = rd_rcvd_q;
    addr_d       = addr_q;
    read_d       = read_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef LPC_FRAME_PINGPONG_EN
    bank_d       = bank_q;
`endif
    case (state_q)
      S_WRITE: begin
        if (accept) begin
          // A new sample may replace a write completing this same cycle.
          write_d     = 1'b1;
          wdata_d     = in_data;
          addr_d      = frame_base + ADDR_W'(wr_issued_q);
          wr_issued_d = wr_issued_q + CW'(1);
        end else if (wr_ack) begin
          write_d = 1'b0;
          if (wr_issued_q == LEN) begin
            // Launch the first read on the same edge the last write retires.
            state_d = S_READ;
            read_d  = 1'b1;
            addr_d  = frame_base;
          end
        end
      end
      S_READ: begin
        if (rd_ack) begin
          rd_issued_d = rd_issued_q + CW'(1);
          if (rd_issued_q == LAST) begin
            read_d  = 1'b0;
            state_d = S_DRAIN;
          end else begin
            addr_d = frame_base + ADDR_W'(rd_issued_d);
          end
        end
      end
      S_DRAIN: begin
        if (rd_rcvd_q == LEN) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_WRITE;
        wr_issued_d = '0;
        rd_issued_d = '0;
        rd_rcvd_d   = '0;
`ifdef LPC_FRAME_PINGPONG_EN
        bank_d      = ~bank_q;
`endif
      end
    endcase

    // Responses only count while reads belong to the current frame; anything
    // arriving in WRITE is left over from before a reset and is dropped.
    if ((state_q == S_READ || state_q == S_DRAIN) && ddr_readdatavalid
        && (rd_rcvd_q != LEN)) begin
      out_data_d  = ddr_readdata;
      out_valid_d = 1'b1;
      out_last_d  = (rd_rcvd_q == LAST);
      rd_rcvd_d   = rd_rcvd_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_WRITE;
      wr_issued_q  <= '0;
      rd_issued_q  <= '0;
      rd_rcvd_q    <= '0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef LPC_FRAME_PINGPONG_EN
      bank_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_issued_q  <= wr_issued_d;
      rd_issued_q  <= rd_issued_d;
      rd_rcvd_q    <= rd_rcvd_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
`ifdef LPC_FRAME_PINGPONG_EN
      bank_q       <= bank_d;
`endif
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign frame_done    = frame_done_q;
  assign ddr_addr      = addr_q;
  assign ddr_read      = read_q;
  assign ddr_write     = write_q;
  assign ddr_writedata = wdata_q;

endmodule

// File: tb/tb_lpc_frame_mm_master.sv
// tb/tb_lpc_frame_mm_master.sv - scoreboard bench for lpc_frame_mm_master
module tb_lpc_frame_mm_master;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int L    = 4;
  localparam int BASE = 8;
  localparam int LAT  = 3;
`ifdef LPC_FRAME_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, frame_done;
  logic [AW-1:0] ddr_addr;
  logic          ddr_read, ddr_write;
  logic [DW-1:0] ddr_writedata;
  logic [DW-1:0] ddr_readdata = '0;
  logic          ddr_readdatavalid = 1'b0;
  logic          ddr_waitrequest = 1'b0;

  always #5 clk = ~clk;

  lpc_frame_mm_master #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(L), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .frame_done(frame_done),
    .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_write(ddr_write),
    .ddr_writedata(ddr_writedata), .ddr_readdata(ddr_readdata),
    .ddr_readdatavalid(ddr_readdatavalid), .ddr_waitrequest(ddr_waitrequest)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got bound expired expected completion", name);
  endtask

  // Reference model: expected write {addr,data}, read addresses, outputs {last,data}
  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [DW:0]      out_q[$];
  int frame_no = 0;
  int idx = 0;
  int cyc = 0;
  int acc_cycle = -10;
  int rd_acc_total = 0;
  bit done_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] base_of(input int f);
    return AW'(BASE) + ((PP && (f % 2 == 1)) ? AW'(L) : AW'(0));
  endfunction

  task automatic model_accept(input logic [DW-1:0] d);
    logic [AW-1:0] a;
    a = base_of(frame_no) + AW'(idx);
    wr_q.push_back({a, d});
    rd_q.push_back(a);
    out_q.push_back({(idx == L - 1), d});
    acc_cycle = cyc;
    idx++;
    if (idx == L) begin
      idx = 0;
      frame_no++;
    end
  endtask

  // Memory model: fixed-latency pipelined reads, random or directed stalls
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];
  int  wr_cnt = 0, rd_cnt = 0, stall_cnt = 0;
  bit  rand_wait = 1'b0, dir_w = 1'b0, dir_r = 1'b0;

  initial begin
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    forever begin
      @(negedge clk);
      ddr_readdatavalid = pv[0];
      ddr_readdata = pd[0];
      for (int i = 0; i < LAT - 1; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
      pv[LAT-1] = 1'b0;
      pd[LAT-1] = '0;
      if (stall_cnt > 0) begin
        ddr_waitrequest = 1'b1;
        stall_cnt--;
      end else if (dir_w && ddr_write === 1'b1 && wr_cnt == 1) begin
        ddr_waitrequest = 1'b1; stall_cnt = 2; dir_w = 1'b0;
      end else if (dir_r && ddr_read === 1'b1 && rd_cnt == 2) begin
        ddr_waitrequest = 1'b1; stall_cnt = 2; dir_r = 1'b0;
      end else begin
        ddr_waitrequest = rand_wait && ($urandom_range(0, 3) == 0);
      end
      if (ddr_write === 1'b1 && !ddr_waitrequest) begin
        mem[ddr_addr] = ddr_writedata;
        wr_cnt = (wr_cnt + 1) % L;
      end
      if (ddr_read === 1'b1 && !ddr_waitrequest) begin
        pv[LAT-1] = 1'b1;
        pd[LAT-1] = mem.exists(ddr_addr) ? mem[ddr_addr] : '0;
        rd_cnt = (rd_cnt + 1) % L;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a command or output
  initial begin
    logic [AW+DW-1:0] we;
    logic [AW-1:0]    ra;
    logic [DW:0]      oe;
    bit               prev_ok, done_next;
    logic             p_wait, p_rd, p_wr;
    logic [AW-1:0]    p_addr;
    logic [DW-1:0]    p_wd;
    prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_ok = 1'b0;
      end else begin
        check("rw_exclusive", 64'(ddr_read && ddr_write), 64'(0));
        assert (!(ddr_read && ddr_write));
        if (acc_cycle == cyc - 1) check("write_latency", 64'(ddr_write), 64'(1));
        if (ddr_write && ddr_waitrequest) check("in_ready_stall", 64'(in_ready), 64'(0));
        if (prev_ok && p_wait && (p_rd || p_wr))
          check("cmd_hold", 64'({ddr_read, ddr_write, ddr_addr, ddr_writedata}),
                64'({p_rd, p_wr, p_addr, p_wd}));
        if (ddr_write && !ddr_waitrequest) begin
          if (wr_q.size() == 0) check("write_unexpected", 64'(ddr_write), 64'(0));
          else begin
            we = wr_q.pop_front();
            check("write_addr", 64'(ddr_addr), 64'(we[AW+DW-1:DW]));
            check("write_data", 64'(ddr_writedata), 64'(we[DW-1:0]));
          end
        end
        if (ddr_read && !ddr_waitrequest) begin
          rd_acc_total++;
          if (rd_q.size() == 0) check("read_unexpected", 64'(ddr_read), 64'(0));
          else begin
            ra = rd_q.pop_front();
            check("read_addr", 64'(ddr_addr), 64'(ra));
          end
        end
        done_next = 1'b0;
        if (out_valid) begin
          if (out_q.size() == 0) check("out_unexpected", 64'(out_valid), 64'(0));
          else begin
            oe = out_q.pop_front();
            check("out_data", 64'(out_data), 64'(oe[DW-1:0]));
            check("out_last", 64'(out_last), 64'(oe[DW]));
            done_next = oe[DW];
          end
        end
        if (frame_done || done_exp) check("frame_done", 64'(frame_done), 64'(done_exp));
        done_exp = done_next;
        prev_ok = 1'b1;
      end
      p_wait = ddr_waitrequest; p_rd = ddr_read; p_wr = ddr_write;
      p_addr = ddr_addr; p_wd = ddr_writedata;
    end
  end

  logic [DW-1:0] dir_data [4];

  // mode 0: directed data, valid held; 1: random data, valid held;
  // 2: valid toggling 1,0,1,0; 3: random valid
  task automatic send_frame(input int mode);
    int sent, t;
    bit ph;
    sent = 0; t = 0; ph = 1'b1;
    while (sent < L) begin
      @(negedge clk);
      case (mode)
        0, 1: in_valid = 1'b1;
        2: begin in_valid = ph; ph = !ph; end
        default: in_valid = ($urandom_range(0, 1) == 1);
      endcase
      in_data = (mode == 0) ? dir_data[sent] : DW'($urandom);
      #1;
      if (in_valid && in_ready) begin
        model_accept(in_data);
        sent++;
      end
      t++;
      if (t > 500) begin bound_fail("send_timeout"); break; end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((out_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) bound_fail("drain_timeout");
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t, target;
    dir_data[0] = 16'd100;
    dir_data[1] = 16'hFFFE;
    dir_data[2] = 16'h7FFF;
    dir_data[3] = 16'h8000;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("in_ready_in_reset", 64'(in_ready), 64'(0));
    end
    check("reset_ctrl", 64'({out_valid, out_last, frame_done, ddr_read, ddr_write}), 64'(0));
    check("reset_data", 64'({out_data, ddr_addr, ddr_writedata}), 64'(0));
    reset = 1'b0;

    send_frame(0);
    wait_idle();
    dir_w = 1'b1;
    dir_r = 1'b1;
    send_frame(1);
    wait_idle();
    send_frame(2);
    wait_idle();
    send_frame(1);
    send_frame(1);
    wait_idle();
    rand_wait = 1'b1;
    repeat (6) send_frame(3);
    wait_idle();

    rand_wait = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    target = rd_acc_total + L;
    send_frame(1);
    t = 0;
    while (rd_acc_total < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) bound_fail("drain_wait_timeout");
    reset = 1'b1;
    #1;
    check("in_ready_mid_reset", 64'(in_ready), 64'(0));
    @(negedge clk);
    #1;
    wr_q.delete();
    rd_q.delete();
    out_q.delete();
    frame_no = 0;
    idx = 0;
    done_exp = 1'b0;
    check("midreset_ctrl", 64'({out_valid, out_last, frame_done, ddr_read, ddr_write}), 64'(0));
    check("midreset_data", 64'({out_data, ddr_addr, ddr_writedata}), 64'(0));
    reset = 1'b0;

    rand_wait = 1'b1;
    repeat (2) send_frame(3);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
